// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB stage: write-back source selects and load funct3 encodings.
package wb_pkg;

  localparam int WB_XLEN = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_IMM  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage inputs, register-file write port and decode operand read port of the MEM/WB stage.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            M_valid;
  logic            M_wb_en;
  logic [4:0]      M_rd_index;
  logic [1:0]      M_wb_sel;
  logic [2:0]      M_funct3;
  logic [1:0]      M_addr_lo;
  logic [XLEN-1:0] M_alu_out;
  logic [XLEN-1:0] M_pc_plus4;
  logic [XLEN-1:0] M_imm;
  logic [XLEN-1:0] M_ld_data;

  logic            W_wb_en;
  logic [4:0]      W_rd_index;
  logic [XLEN-1:0] wb_data;

  logic [4:0]      D_rs1_index;
  logic [4:0]      D_rs2_index;
  logic [XLEN-1:0] D_rs1_rf;
  logic [XLEN-1:0] D_rs2_rf;
  logic [XLEN-1:0] D_rs1_data;
  logic [XLEN-1:0] D_rs2_data;

  logic [CNT_W-1:0] instret;

  modport master (
    output M_valid, M_wb_en, M_rd_index, M_wb_sel, M_funct3, M_addr_lo,
           M_alu_out, M_pc_plus4, M_imm, M_ld_data,
           D_rs1_index, D_rs2_index, D_rs1_rf, D_rs2_rf,
    input  W_wb_en, W_rd_index, wb_data, D_rs1_data, D_rs2_data, instret
  );

  modport slave (
    input  M_valid, M_wb_en, M_rd_index, M_wb_sel, M_funct3, M_addr_lo,
           M_alu_out, M_pc_plus4, M_imm, M_ld_data,
           D_rs1_index, D_rs2_index, D_rs1_rf, D_rs2_rf,
    output W_wb_en, W_rd_index, wb_data, D_rs1_data, D_rs2_data, instret
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load extractor: picks byte/half/word from the aligned memory word and extends it.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] value_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (addr_lo_i)
      2'd0: byte_v = word_i[7:0];
      2'd1: byte_v = word_i[15:8];
      2'd2: byte_v = word_i[23:16];
      2'd3: byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    // Misaligned half loads are not trapped here; bit 0 is simply dropped.
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    value_o = '0;
    case (funct3_i)
      F3_LB:   value_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  value_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   value_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  value_o = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   value_o = word_i;
      default: value_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back mux, retired-instruction counter.
// Build option WB_BYPASS_EN forwards the write port onto the decode operand reads.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int CNT_W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  wb_stage_if.slave     bus
);

  logic            w_valid_q,   w_valid_d;
  logic            w_wb_en_q,   w_wb_en_d;
  logic [4:0]      w_rd_q,      w_rd_d;
  logic [1:0]      w_sel_q,     w_sel_d;
  logic [2:0]      w_f3_q,      w_f3_d;
  logic [1:0]      w_addr_lo_q, w_addr_lo_d;
  logic [XLEN-1:0] w_alu_q,     w_alu_d;
  logic [XLEN-1:0] w_pc4_q,     w_pc4_d;
  logic [XLEN-1:0] w_imm_q,     w_imm_d;
  logic [XLEN-1:0] w_ld_q,      w_ld_d;
  logic [CNT_W-1:0] instret_q,  instret_d;

  logic [XLEN-1:0] ld_value;
  logic [XLEN-1:0] wb_data;
  logic            wb_en;

  always_comb begin
    w_valid_d   = w_valid_q;
    w_wb_en_d   = w_wb_en_q;
    w_rd_d      = w_rd_q;
    w_sel_d     = w_sel_q;
    w_f3_d      = w_f3_q;
    w_addr_lo_d = w_addr_lo_q;
    w_alu_d     = w_alu_q;
    w_pc4_d     = w_pc4_q;
    w_imm_d     = w_imm_q;
    w_ld_d      = w_ld_q;
    if (flush) begin
      w_valid_d   = 1'b0;
      w_wb_en_d   = 1'b0;
      w_rd_d      = '0;
      w_sel_d     = '0;
      w_f3_d      = '0;
      w_addr_lo_d = '0;
      w_alu_d     = '0;
      w_pc4_d     = '0;
      w_imm_d     = '0;
      w_ld_d      = '0;
    end else if (!stall) begin
      w_valid_d   = bus.M_valid;
      w_wb_en_d   = bus.M_wb_en;
      w_rd_d      = bus.M_rd_index;
      w_sel_d     = bus.M_wb_sel;
      w_f3_d      = bus.M_funct3;
      w_addr_lo_d = bus.M_addr_lo;
      w_alu_d     = bus.M_alu_out;
      w_pc4_d     = bus.M_pc_plus4;
      w_imm_d     = bus.M_imm;
      w_ld_d      = bus.M_ld_data;
    end
  end

  // The instruction leaving W retires even if a flush overwrites the register behind it.
  always_comb begin
    instret_d = instret_q;
    if (w_valid_q && !stall) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_valid_q   <= 1'b0;
      w_wb_en_q   <= 1'b0;
      w_rd_q      <= '0;
      w_sel_q     <= '0;
      w_f3_q      <= '0;
      w_addr_lo_q <= '0;
      w_alu_q     <= '0;
      w_pc4_q     <= '0;
      w_imm_q     <= '0;
      w_ld_q      <= '0;
      instret_q   <= '0;
    end else begin
      w_valid_q   <= w_valid_d;
      w_wb_en_q   <= w_wb_en_d;
      w_rd_q      <= w_rd_d;
      w_sel_q     <= w_sel_d;
      w_f3_q      <= w_f3_d;
      w_addr_lo_q <= w_addr_lo_d;
      w_alu_q     <= w_alu_d;
      w_pc4_q     <= w_pc4_d;
      w_imm_q     <= w_imm_d;
      w_ld_q      <= w_ld_d;
      instret_q   <= instret_d;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i  (w_f3_q),
    .addr_lo_i (w_addr_lo_q),
    .word_i    (w_ld_q),
    .value_o   (ld_value)
  );

  always_comb begin
    wb_data = w_alu_q;
    case (wb_sel_e'(w_sel_q))
      WB_SEL_ALU:  wb_data = w_alu_q;
      WB_SEL_LOAD: wb_data = ld_value;
      WB_SEL_PC4:  wb_data = w_pc4_q;
      WB_SEL_IMM:  wb_data = w_imm_q;
      default:     wb_data = w_alu_q;
    endcase
  end

  assign wb_en          = w_valid_q && w_wb_en_q && (w_rd_q != 5'd0);
  assign bus.W_wb_en    = wb_en;
  assign bus.W_rd_index = w_rd_q;
  assign bus.wb_data    = wb_data;
  assign bus.instret    = instret_q;

`ifdef WB_BYPASS_EN
  // wb_en already excludes x0, so a read of x0 never picks up forwarded data.
  assign bus.D_rs1_data = (wb_en && bus.D_rs1_index == w_rd_q) ? wb_data : bus.D_rs1_rf;
  assign bus.D_rs2_data = (wb_en && bus.D_rs2_index == w_rd_q) ? wb_data : bus.D_rs2_rf;
`else
  logic unused_rs_index;
  assign unused_rs_index = ^{bus.D_rs1_index, bus.D_rs2_index};
  assign bus.D_rs1_data  = bus.D_rs1_rf;
  assign bus.D_rs2_data  = bus.D_rs2_rf;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-instruction vectors plus stall/flush/reset/bypass sequences.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        wb_en;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] ld;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  logic [63:0] exp_instret;
  logic        prev_valid;

  function automatic vec_t mk(logic valid, logic wb_en, logic [4:0] rd, logic [1:0] sel,
                              logic [2:0] f3, logic [1:0] alo, logic [31:0] alu,
                              logic [31:0] pc4, logic [31:0] imm, logic [31:0] ld,
                              logic exp_en, logic [31:0] exp_data);
    vec_t v;
    v.valid = valid; v.wb_en = wb_en; v.rd = rd; v.sel = sel; v.f3 = f3; v.alo = alo;
    v.alu = alu; v.pc4 = pc4; v.imm = imm; v.ld = ld;
    v.exp_en = exp_en; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.M_valid    = v.valid;
    bus.M_wb_en    = v.wb_en;
    bus.M_rd_index = v.rd;
    bus.M_wb_sel   = v.sel;
    bus.M_funct3   = v.f3;
    bus.M_addr_lo  = v.alo;
    bus.M_alu_out  = v.alu;
    bus.M_pc_plus4 = v.pc4;
    bus.M_imm      = v.imm;
    bus.M_ld_data  = v.ld;
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    logic [31:0] exp_rs1;
    idle = mk(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // ALU, every load flavour, PC+4, imm, x0 and non-valid cases; ld word 0x80FF7F01
    vecs.push_back(mk(1, 1, 5,  2'd0, 3'b000, 2'd0, 32'h12345678, 32'h0, 32'h0, 32'h0,        1, 32'h12345678));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b000, 2'd3, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'hFFFFFF80));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b100, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h0000007F));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b001, 2'd2, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'hFFFF80FF));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b101, 2'd0, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h00007F01));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b011, 2'd0, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h00000000));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b010, 2'd2, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h80FF7F01));
    vecs.push_back(mk(1, 1, 6,  2'd1, 3'b001, 2'd3, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'hFFFF80FF));
    vecs.push_back(mk(1, 1, 8,  2'd1, 3'b100, 2'd2, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h000000FF));
    vecs.push_back(mk(1, 1, 8,  2'd1, 3'b000, 2'd1, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h0000007F));
    vecs.push_back(mk(1, 1, 1,  2'd2, 3'b000, 2'd0, 32'h0, 32'h00001004, 32'h0, 32'h0,        1, 32'h00001004));
    vecs.push_back(mk(1, 1, 31, 2'd3, 3'b000, 2'd0, 32'h0, 32'h0, 32'hABCDE000, 32'h0,        1, 32'hABCDE000));
    vecs.push_back(mk(1, 1, 0,  2'd0, 3'b000, 2'd0, 32'h00000055, 32'h0, 32'h0, 32'h0,        0, 32'h00000055));
    vecs.push_back(mk(0, 1, 9,  2'd0, 3'b000, 2'd0, 32'h00000077, 32'h0, 32'h0, 32'h0,        0, 32'h00000077));
    vecs.push_back(mk(1, 0, 10, 2'd0, 3'b000, 2'd0, 32'h00000066, 32'h0, 32'h0, 32'h0,        0, 32'h00000066));
    vecs.push_back(mk(1, 1, 12, 2'd1, 3'b101, 2'd3, 32'h0, 32'h0, 32'h0, 32'h80FF7F01,        1, 32'h000080FF));

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bus.D_rs1_index = 5'd0; bus.D_rs2_index = 5'd0;
    bus.D_rs1_rf = 32'h0; bus.D_rs2_rf = 32'h0;
    drive(mk(1, 1, 5, 2'd0, 3'd0, 2'd0, 32'h111, 32'h0, 32'h0, 32'h0, 0, 32'h0));

    // Reset held two cycles with a valid instruction waiting in M.
    @(negedge clk);
    @(negedge clk);
    chk("reset_wb_en",   {63'h0, bus.W_wb_en}, 64'h0);
    chk("reset_rd",      {59'h0, bus.W_rd_index}, 64'h0);
    chk("reset_wb_data", {32'h0, bus.wb_data}, 64'h0);
    chk("reset_instret", bus.instret, 64'h0);

    rst_n = 1'b1;
    exp_instret = 64'h0;
    prev_valid  = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      @(negedge clk);
      if (prev_valid) exp_instret = exp_instret + 64'd1;
      prev_valid = v.valid;
      chk($sformatf("vec%0d_wb_en", i),   {63'h0, bus.W_wb_en}, {63'h0, v.exp_en});
      chk($sformatf("vec%0d_rd", i),      {59'h0, bus.W_rd_index}, {59'h0, v.rd});
      chk($sformatf("vec%0d_data", i),    {32'h0, bus.wb_data}, {32'h0, v.exp_data});
      chk($sformatf("vec%0d_instret", i), bus.instret, exp_instret);
    end

    // Stall: rd7/0xA5 stays on the write port while M changes underneath.
    drive(mk(1, 1, 7, 2'd0, 3'd0, 2'd0, 32'h000000A5, 32'h0, 32'h0, 32'h0, 1, 32'h0));
    @(negedge clk);
    if (prev_valid) exp_instret = exp_instret + 64'd1;
    chk("stall_load_data", {32'h0, bus.wb_data}, 64'hA5);
    chk("stall_load_instret", bus.instret, exp_instret);
    stall = 1'b1;
    drive(mk(1, 1, 8, 2'd0, 3'd0, 2'd0, 32'h00000099, 32'h0, 32'h0, 32'h0, 1, 32'h0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_wb_en", c), {63'h0, bus.W_wb_en}, 64'h1);
      chk($sformatf("stall%0d_rd", c),    {59'h0, bus.W_rd_index}, 64'h7);
      chk($sformatf("stall%0d_data", c),  {32'h0, bus.wb_data}, 64'hA5);
      chk($sformatf("stall%0d_instret", c), bus.instret, exp_instret);
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_over_stall_wb_en", {63'h0, bus.W_wb_en}, 64'h0);
    flush = 1'b0;

    // Reset while stalled restarts from an empty pipe.
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_stall_instret", bus.instret, 64'h0);
    chk("reset_mid_stall_wb_en", {63'h0, bus.W_wb_en}, 64'h0);
    rst_n = 1'b1; stall = 1'b0;
    drive(mk(1, 1, 3, 2'd0, 3'd0, 2'd0, 32'h0000DEAD, 32'h0, 32'h0, 32'h0, 1, 32'h0));
    @(negedge clk);
    chk("post_reset_wb_en", {63'h0, bus.W_wb_en}, 64'h1);
    chk("post_reset_instret", bus.instret, 64'h0);

    bus.D_rs1_index = 5'd3; bus.D_rs1_rf = 32'h0;
    bus.D_rs2_index = 5'd4; bus.D_rs2_rf = 32'h00004444;
`ifdef WB_BYPASS_EN
    exp_rs1 = 32'h0000DEAD;
`else
    exp_rs1 = 32'h0;
`endif
    #1;
    chk("bypass_rs1_hit",  {32'h0, bus.D_rs1_data}, {32'h0, exp_rs1});
    chk("bypass_rs2_miss", {32'h0, bus.D_rs2_data}, 64'h4444);

    // Flush without stall: the departing instruction still retires.
    flush = 1'b1;
    drive(mk(1, 1, 9, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0, 32'h0, 1, 32'h0));
    @(negedge clk);
    chk("flush_wb_en", {63'h0, bus.W_wb_en}, 64'h0);
    chk("flush_instret", bus.instret, 64'h1);
    flush = 1'b0;

    drive(mk(1, 1, 0, 2'd0, 3'd0, 2'd0, 32'h0000BEEF, 32'h0, 32'h0, 32'h0, 0, 32'h0));
    @(negedge clk);
    chk("x0_wb_en", {63'h0, bus.W_wb_en}, 64'h0);
    chk("after_flush_instret", bus.instret, 64'h1);
    bus.D_rs1_index = 5'd0; bus.D_rs1_rf = 32'h00001234;
    #1;
    chk("bypass_x0_rs1", {32'h0, bus.D_rs1_data}, 64'h1234);

    drive(idle);
    @(negedge clk);
    chk("x0_retire_instret", bus.instret, 64'h2);
    @(negedge clk);
    chk("idle_instret", bus.instret, 64'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
